// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall / multi-cycle
// execute sequencer.
//   - stall vector constants (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB)
//   - sequencer state encodings (2 bits)
//   - divider start levels
package pipe_ctrl_pkg;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;  // freeze PC, IF, ID
    localparam logic [5:0] StallEx   = 6'b001111;  // freeze PC, IF, ID, EX

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMc2  = 2'd1,
        StDiv  = 2'd2
    } state_t;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges decode/execute stall requests into the per-stage stall
// vector, sequences two-cycle EX ops (madd/msub family) and handshakes with
// the iterative divider, with a watchdog that aborts a divide that never
// completes. A flush aborts any in-flight multi-cycle op.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stallreq_id_i   decode hazard bubble request
//   ex_mcyc_i       EX holds a two-cycle op
//   ex_div_i        EX holds div/divu
//   div_ready_i     divider result valid (single-cycle pulse)
//   flush_i         kill everything in flight (highest priority)
//   stall_o[5:0]    stall vector, combinational from state and inputs
//   ex_cnt_o[1:0]   cycle index of the two-cycle op
//   div_start_o     level start to divider, held until ready
//   div_annul_o     one-cycle cancel to divider
//   busy_o          sequencer not idle
//   timeout_o       sticky watchdog error flag
//
// Divider handshake: div_start_o is a level held high from the accepting
// IDLE cycle until the cycle div_ready_i pulses; in that ready cycle start
// and stall drop together so EX/MEM captures the result. div_annul_o is a
// one-cycle pulse that ends the request without a result.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id_i,
    input  logic       ex_mcyc_i,
    input  logic       ex_div_i,
    input  logic       div_ready_i,
    input  logic       flush_i,
    output logic [5:0] stall_o,
    output logic [1:0] ex_cnt_o,
    output logic       div_start_o,
    output logic       div_annul_o,
    output logic       busy_o,
    output logic       timeout_o
);

    // The watchdog is cleared when IDLE accepts the divide and counts every
    // DIV cycle. The accepting cycle already drives div_start_o, so DIV cycle
    // k has seen k start cycles while the counter holds k-1: the abort fires
    // once DIV_TIMEOUT start cycles have gone by without ready.
    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WdogMax  = CNT_W'(DIV_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wdog;
    logic             timeout_q;
    logic             wdog_hit;

    assign wdog_hit = (state == StDiv) && (wdog >= WdogLast);

    // State register, watchdog and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (flush_i || (state == StIdle && ex_div_i)) begin
                wdog <= '0;
            end else if (state == StDiv && !div_ready_i && wdog != WdogMax) begin
                wdog <= wdog + CNT_W'(1);  // saturates, never wraps
            end
            if (!flush_i && state == StDiv && !div_ready_i && wdog_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = StIdle;
        end else begin
            unique case (state)
                StIdle: begin
                    if (ex_div_i) begin
                        state_next = StDiv;   // div wins over a two-cycle op
                    end else if (ex_mcyc_i) begin
                        state_next = StMc2;
                    end
                end
                StMc2:   state_next = StIdle;
                StDiv: begin
                    if (div_ready_i || wdog_hit) begin
                        state_next = StIdle;
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        stall_o     = StallNone;
        ex_cnt_o    = 2'd0;
        div_start_o = DivStop;
        div_annul_o = 1'b0;
        // During reset every output is held low; the divider resets on the
        // same rst, so no annul is sent for a divide cut off by reset.
        if (!rst) begin
            if (flush_i) begin
                div_annul_o = (state == StDiv);
            end else begin
                unique case (state)
                    StIdle: begin
                        if (ex_div_i) begin
                            div_start_o = DivStart;
                            stall_o     = StallEx;
                        end else if (ex_mcyc_i) begin
                            stall_o = StallEx;
                        end else if (stallreq_id_i) begin
                            stall_o = StallId;
                        end
                    end
                    StMc2: begin
                        ex_cnt_o = 2'd1;
                        if (stallreq_id_i) begin
                            stall_o = StallId;
                        end
                    end
                    StDiv: begin
                        if (div_ready_i) begin
                            // Release the pipe in the ready cycle so the
                            // result is captured.
                            stall_o = StallNone;
                        end else if (wdog_hit) begin
                            div_annul_o = 1'b1;
                        end else begin
                            div_start_o = DivStart;
                            stall_o     = StallEx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o    = !rst && (state != StIdle);
    assign timeout_o = timeout_q && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven bench for pipe_ctrl. Each vector holds one
// cycle of inputs and the outputs expected in that cycle; the expected value
// is pushed to a scoreboard queue when the vector is driven and popped and
// compared mid-cycle. Long multi-cycle sequences are built with loops.
module tb_pipe_ctrl;

  import pipe_ctrl_pkg::*;

  localparam int DIV_TIMEOUT = 40;
  localparam int CNT_W       = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id_i;
  logic       ex_mcyc_i;
  logic       ex_div_i;
  logic       div_ready_i;
  logic       flush_i;
  logic [5:0] stall_o;
  logic [1:0] ex_cnt_o;
  logic       div_start_o;
  logic       div_annul_o;
  logic       busy_o;
  logic       timeout_o;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .DIV_TIMEOUT(DIV_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_mcyc_i    (ex_mcyc_i),
    .ex_div_i     (ex_div_i),
    .div_ready_i  (div_ready_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .ex_cnt_o     (ex_cnt_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  typedef struct {
    logic        r;
    logic        id;
    logic        mc;
    logic        dv;
    logic        rdy;
    logic        fl;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  // Expected-output packer: {stall, ex_cnt, start, annul, busy, timeout}
  function automatic logic [11:0] pk(input logic [5:0] st, input logic [1:0] c,
                                     input logic s, input logic a,
                                     input logic b, input logic t);
    return {st, c, s, a, b, t};
  endfunction

  task automatic add(input logic r, input logic id, input logic mc, input logic dv,
                     input logic rdy, input logic fl, input logic [11:0] e,
                     input string nm);
    vec_t v;
    v.r = r; v.id = id; v.mc = mc; v.dv = dv; v.rdy = rdy; v.fl = fl;
    v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_out(input int idx);
    logic [11:0] got;
    logic [11:0] e;
    string       nm;
    got = {stall_o, ex_cnt_o, div_start_o, div_annul_o, busy_o, timeout_o};
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_checks++;
    if (got === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s (vec %0d): got stall=%b cnt=%0d start=%b annul=%b busy=%b tmo=%b, want stall=%b cnt=%0d start=%b annul=%b busy=%b tmo=%b",
               nm, idx, got[11:6], got[5:4], got[3], got[2], got[1], got[0],
               e[11:6], e[5:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < 3; i++)
      add(1'b1, rb(), rb(), rb(), rb(), rb(), pk(S0, 2'd0, 0, 0, 0, 0), "reset");
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 0), "idle_after_reset");

    // Two-cycle op, plain and with an ID stall in the second cycle
    add(0, 0, 1, 0, 0, 0, pk(SE, 2'd0, 0, 0, 0, 0), "mc_first");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd1, 0, 0, 1, 0), "mc_second");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 0), "mc_done");
    add(0, 0, 1, 0, 0, 0, pk(SE, 2'd0, 0, 0, 0, 0), "mc_first_b");
    add(0, 1, 0, 0, 0, 0, pk(SI, 2'd1, 0, 0, 1, 0), "mc_second_idstall");
    add(0, 1, 0, 0, 0, 0, pk(SI, 2'd0, 0, 0, 0, 0), "id_stall_idle");
    // EX stall overrides an ID stall
    add(0, 1, 1, 0, 0, 0, pk(SE, 2'd0, 0, 0, 0, 0), "ex_over_id");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd1, 0, 0, 1, 0), "ex_over_id_second");
    add(0, 0, 0, 0, 1, 0, pk(S0, 2'd0, 0, 0, 0, 0), "ready_ignored_idle");

    // Divide with ready after 33 start cycles
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 0), "div_accept");
    for (int k = 1; k <= 32; k++)
      add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 1, 0), "div_wait");
    add(0, 0, 0, 1, 1, 0, pk(S0, 2'd0, 0, 0, 1, 0), "div_ready");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 0), "div_done");

    // Divide that never completes: watchdog abort after DIV_TIMEOUT start cycles
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 0), "to_accept");
    for (int k = 1; k < DIV_TIMEOUT; k++)
      add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 1, 0), "to_wait");
    add(0, 0, 0, 1, 0, 0, pk(S0, 2'd0, 0, 1, 1, 0), "div_timeout");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 1), "timeout_sticky");

    // Next divide proceeds normally (ready after 3 start cycles)
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 1), "div2_accept");
    for (int k = 1; k <= 2; k++)
      add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 1, 1), "div2_wait");
    add(0, 0, 0, 1, 1, 0, pk(S0, 2'd0, 0, 0, 1, 1), "div2_ready");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 1), "div2_done");

    // Flush at DIV cycle 10, then a stray ready pulse
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 1), "fl_accept");
    for (int k = 1; k <= 9; k++)
      add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 1, 1), "fl_wait");
    add(0, 0, 0, 1, 0, 1, pk(S0, 2'd0, 0, 1, 1, 1), "flush_div");
    add(0, 0, 0, 0, 1, 0, pk(S0, 2'd0, 0, 0, 0, 1), "flush_late_ready");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 1), "flush_idle");

    // All requests together: div wins
    add(0, 1, 1, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 1), "all_req_div_wins");
    add(0, 0, 0, 1, 1, 0, pk(S0, 2'd0, 0, 0, 1, 1), "all_req_ready");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 1), "all_req_done");

    // Flush in IDLE blocks the accept
    add(0, 0, 0, 1, 0, 1, pk(S0, 2'd0, 0, 0, 0, 1), "flush_idle_div");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 1), "flush_idle_stays");

    // Reset mid-DIV: no annul, timeout cleared
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 0, 1), "rst_accept");
    add(0, 0, 0, 1, 0, 0, pk(SE, 2'd0, 1, 0, 1, 1), "rst_wait");
    add(1, 0, 0, 1, 0, 0, pk(S0, 2'd0, 0, 0, 0, 0), "reset_mid_div");
    add(0, 0, 0, 0, 0, 0, pk(S0, 2'd0, 0, 0, 0, 0), "after_reset");

    // ---------------- apply ----------------
    rst = 1'b1; stallreq_id_i = 1'b0; ex_mcyc_i = 1'b0;
    ex_div_i = 1'b0; div_ready_i = 1'b0; flush_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].r;
      stallreq_id_i = vecs[i].id;
      ex_mcyc_i     = vecs[i].mc;
      ex_div_i      = vecs[i].dv;
      div_ready_i   = vecs[i].rdy;
      flush_i       = vecs[i].fl;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      @(negedge clk);
      if (vecs[i].name == "reset" || vecs[i].name == "reset_mid_div") begin
        check_out(i);
      end else if (vecs[i].name == "div_timeout") begin
        check_out(i);
      end else begin
        check_out(i);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
